// File: rtl/neuron_window_classifier_pkg.sv
// Shared definitions for the window classifier: FSM state encoding and default sizing.
// Reused by the classifier and its testbench.
package neuron_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEF_WINDOW      = 8;
   localparam int DEF_VOTE_THRESH = 4;
   localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/neuron_window_classifier.sv
// Rate-codes the layer-2 spike stream: counts spikes over WINDOW accepted samples and
// presents a majority-vote decision on a valid/ready port. Option: NEURON_WIN_AUTO_RESTART_EN.
module neuron_window_classifier
   import neuron_pkg::*;
#(
   parameter int WINDOW      = DEF_WINDOW,
   parameter int VOTE_THRESH = DEF_VOTE_THRESH,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             in_spike,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_class,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   generate
      if ((WINDOW < 1) || ((2 ** CNT_W) <= WINDOW)) begin : g_bad_cfg
         $error("neuron_window_classifier: CNT_W too small for WINDOW, or WINDOW < 1");
      end
   endgenerate

`ifdef NEURON_WIN_AUTO_RESTART_EN
   localparam bit AUTO_RESTART = 1'b1;
`else
   localparam bit AUTO_RESTART = 1'b0;
`endif

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] idx_reg, idx_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             class_reg, class_next;
   logic             valid_reg;
   logic [CNT_W-1:0] sum;
   logic             accept;

   assign accept = in_valid && (state_reg == ACCUM);
   assign sum    = cnt_reg + CNT_W'(in_spike);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      count_next = count_reg;
      class_next = class_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = ACCUM;
               idx_next   = '0;
               cnt_next   = '0;
            end
         end
         ACCUM: begin
            // A restart wins over the sample offered in the same cycle.
            if (start) begin
               idx_next = '0;
               cnt_next = '0;
            end else if (accept) begin
               if (int'(idx_reg) == WINDOW - 1) begin
                  state_next = HOLD;
                  idx_next   = '0;
                  cnt_next   = '0;
                  count_next = sum;
                  class_next = (int'(sum) >= VOTE_THRESH);
               end else begin
                  idx_next = idx_reg + CNT_W'(1);
                  cnt_next = sum;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (start || AUTO_RESTART) begin
                  state_next = ACCUM;
                  idx_next   = '0;
                  cnt_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         count_reg <= '0;
         class_reg <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         count_reg <= count_next;
         class_reg <= class_next;
         valid_reg <= (state_next == HOLD);
      end
   end

   assign in_ready  = (state_reg == ACCUM);
   assign busy      = (state_reg == ACCUM) || (state_reg == HOLD);
   assign out_valid = valid_reg;
   assign out_class = class_reg;
   assign out_count = count_reg;

endmodule

// File: tb/tb_neuron_window_classifier.sv
// Directed and randomized checks of neuron_window_classifier against a spike-sum model.
// Expectations follow NEURON_WIN_AUTO_RESTART_EN when it is defined.
module tb_neuron_window_classifier;
   import neuron_pkg::*;

   localparam int W  = DEF_WINDOW;
   localparam int TH = DEF_VOTE_THRESH;
   localparam int CW = DEF_CNT_W;

`ifdef NEURON_WIN_AUTO_RESTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_spike = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_class;
   logic [CW-1:0] out_count;
   logic          busy;

   int total = 0;
   int bad   = 0;

   neuron_window_classifier #(.WINDOW(W), .VOTE_THRESH(TH), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_spike  (in_spike),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Feeds one window of samples (bit i = sample i) with random idle gaps,
   // then checks the decision against the sum of the accepted spikes.
   task automatic run_window(input string tag, input logic [W-1:0] spikes, input int gap_max);
      int exp_cnt;
      exp_cnt = $countones(spikes);
      for (int i = 0; i < W; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         in_valid = 1'b0;
         repeat (g) tick();
         in_valid = 1'b1;
         in_spike = spikes[i];
         if (i == 0 || i == W - 1) chk({tag, "_in_ready"}, in_ready, 1);
         tick();
         in_valid = 1'b0;
         if (i == W - 2) chk({tag, "_early_valid"}, out_valid, 0);
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_count"}, out_count, exp_cnt);
      chk({tag, "_class"}, out_class, (exp_cnt >= TH) ? 1 : 0);
      $display("window %s: spikes=%b expected count=%0d class=%0d", tag, spikes, exp_cnt,
               (exp_cnt >= TH) ? 1 : 0);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, out_valid, 0);
      chk({tag, "_hs_busy"}, busy, AUTO ? 1 : 0);
   endtask

   initial begin
      logic [W-1:0] pat;
      logic [CW-1:0] held_cnt;
      logic          held_cls;

      // Reset asserted while a window is in progress
      rst = 1'b0;
      tick();
      pulse_start();
      in_valid = 1'b1; in_spike = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      tick(); tick();
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_class", out_class, 0);
      in_valid = 1'b1; in_spike = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);

      // Spikes 1,1,0,1,1,0,0,0 -> count 4, class 1; hold with out_ready low
      pulse_start();
      chk("t1_busy", busy, 1);
      run_window("t1", 8'b0001_1011, 0);
      held_cnt = out_count;
      held_cls = out_class;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         tick();
         start = 1'b0;
         chk("t1_hold_valid", out_valid, 1);
         chk("t1_hold_count", out_count, 4);
         chk("t1_hold_class", out_class, 1);
         chk("t1_hold_in_ready", in_ready, 0);
      end
      handshake("t1");

      // Three spikes at random positions, gapped input
      pat = '0;
      while ($countones(pat) < 3) pat[$urandom_range(W - 1, 0)] = 1'b1;
      pulse_start();
      run_window("t2", pat, 3);
      handshake("t2");

      // Partial window of five spikes discarded by a restart; offered sample dropped
      pulse_start();
      in_valid = 1'b1; in_spike = 1'b1;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      run_window("t3", 8'b0100_0010, 1);

      // Handshake and start together go straight to ACCUM
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      chk("t4_in_ready", in_ready, 1);
      chk("t4_out_valid", out_valid, 0);
      run_window("t4", W'($urandom), 1);
      handshake("t4");

      // Randomized windows with random consumer delay
      for (int k = 0; k < 10; k++) begin
         int d;
         pulse_start();
         run_window("rnd", W'($urandom), 2);
         held_cnt = out_count;
         held_cls = out_class;
         d = $urandom_range(3, 0);
         repeat (d) tick();
         chk("rnd_stable_count", out_count, held_cnt);
         chk("rnd_stable_class", out_class, held_cls);
         handshake("rnd");
      end

      // Asynchronous reset while a decision is pending
      pulse_start();
      run_window("t6a", 8'b1111_1111, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", out_valid, 0);
      chk("t6_async_count", out_count, 0);
      chk("t6_async_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      pulse_start();
      run_window("t6", 8'b0000_0000, 1);
      handshake("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
